// File: rtl/mult_sched.sv
// mult_sched: arbitrates N_REQ requesters onto one shift-add multiplier datapath and sequences it.
// Define MULT_SCHED_RR_EN for round-robin arbitration; otherwise the lowest pending index wins.
module mult_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_lsb,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_sel,
  output logic             o_load,
  output logic             o_add,
  output logic             o_shift,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDW-1:0]   o_done_id
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   sel_q;
  logic [IDW-1:0]   done_id_q;
  logic             load_q;
  logic             add_q;
  logic             shift_q;
  logic             busy_q;
  logic             done_q;

  logic [IDW-1:0]   base_c;
  logic [IDW-1:0]   idx_c;
  logic [IDW-1:0]   win_c;
  logic             found_c;
  logic             arb_fire_c;

  assign arb_fire_c = ((state_q == S_IDLE) || (state_q == S_DONE)) && found_c;

`ifdef MULT_SCHED_RR_EN
  logic [IDW-1:0] ptr_q;

  assign base_c = ptr_q;

  // Priority restarts just past the most recent winner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else if (arb_fire_c) begin
      ptr_q <= IDW'((32'(win_c) + 32'd1) % N_REQ);
    end
  end
`else
  assign base_c = '0;
`endif

  // Scan requesters starting at base_c; first pending one wins.
  always_comb begin
    win_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_c = IDW'((32'(base_c) + i) % N_REQ);
      if (!found_c && i_req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Sequencer: outputs are registered alongside the state they decode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      done_id_q <= '0;
      load_q    <= 1'b0;
      add_q     <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      gnt_q   <= '0;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (found_c) begin
            state_q <= S_INIT;
            sel_q   <= win_c;
            gnt_q   <= N_REQ'(1) << win_c;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_INIT: begin
          state_q <= S_CHECK;
          cnt_q   <= '0;
        end
        S_CHECK: begin
          if (i_lsb) begin
            state_q <= S_ADD;
            add_q   <= 1'b1;
          end else begin
            state_q <= S_SHIFT;
            shift_q <= 1'b1;
          end
        end
        S_ADD: begin
          state_q <= S_SHIFT;
          shift_q <= 1'b1;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(WIDTH - 1)) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            done_id_q <= sel_q;
          end else begin
            state_q <= S_CHECK;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = gnt_q;
  assign o_sel     = sel_q;
  assign o_load    = load_q;
  assign o_add     = add_q;
  assign o_shift   = shift_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_done_id = done_id_q;

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed bench with a shift-add datapath model and an in-order scoreboard of expected operations.
module tb_mult_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned IW   = 2;

  logic            i_clk;
  logic            i_rst;
  logic [NREQ-1:0] i_req;
  logic            i_lsb;
  logic [NREQ-1:0] o_gnt;
  logic [IW-1:0]   o_sel;
  logic            o_load;
  logic            o_add;
  logic            o_shift;
  logic            o_busy;
  logic            o_done;
  logic [IW-1:0]   o_done_id;

  mult_sched #(.N_REQ(NREQ), .WIDTH(W), .IDW(IW)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (i_req),
    .i_lsb    (i_lsb),
    .o_gnt    (o_gnt),
    .o_sel    (o_sel),
    .o_load   (o_load),
    .o_add    (o_add),
    .o_shift  (o_shift),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_done_id(o_done_id)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          lat;
    int          adds;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int init_cyc = 0;
  int add_cnt = 0;
  int shift_cnt = 0;
  int gnt_total = 0;
  int done_total = 0;
  int last_done_cyc = -10;

  logic [7:0] a_op [NREQ];
  logic [7:0] b_op [NREQ];
  bit         sticky [NREQ];
  bit         rearm_pend [NREQ];
  int         rearm_left [NREQ];

  // Datapath model: multiplier register feeding i_lsb, shifted multiplicand, accumulator.
  logic [7:0]  mreg_q;
  logic [15:0] aval_q;
  logic [15:0] acc_q;

  assign i_lsb = mreg_q[0];

  always_ff @(posedge i_clk) begin
    if (o_load) begin
      mreg_q <= b_op[o_sel];
      aval_q <= {8'h00, a_op[o_sel]};
      acc_q  <= '0;
    end else begin
      if (o_add) acc_q <= acc_q + aval_q;
      if (o_shift) begin
        mreg_q <= mreg_q >> 1;
        aval_q <= aval_q << 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int id);
    return NREQ'(1) << id;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({o_gnt, o_sel, o_load, o_add, o_shift, o_busy, o_done, o_done_id});
  endfunction

  task automatic push(input int id);
    exp_t e;
    e.id   = id;
    e.prod = 16'(a_op[IW'(id)]) * 16'(b_op[IW'(id)]);
    e.adds = $countones(b_op[IW'(id)]);
    e.lat  = 1 + 2 * int'(W) + e.adds;
    sbq.push_back(e);
  endtask

  // One clock: sample after the edge, model requesters, score grants and completions.
  task automatic tick();
    exp_t e;
    @(posedge i_clk);
    #1;
    cyc++;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (rearm_pend[k]) begin
        i_req[IW'(k)] = 1'b1;
        rearm_pend[k] = 1'b0;
      end
    end
    if (o_add === 1'b1) add_cnt++;
    if (o_shift === 1'b1) shift_cnt++;
    if (o_gnt !== '0) begin
      gnt_total++;
      check("gnt_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        check("gnt_onehot", 32'(o_gnt), 32'(onehot(sbq[0].id)));
        check("sel", 32'(o_sel), 32'(sbq[0].id));
      end
      init_cyc  = cyc;
      add_cnt   = 0;
      shift_cnt = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (o_gnt[IW'(k)] && !sticky[k]) i_req[IW'(k)] = 1'b0;
      end
    end
    if (o_done === 1'b1) begin
      done_total++;
      last_done_cyc = cyc;
      check("done_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("done_id", 32'(o_done_id), 32'(e.id));
        check("product", 32'(acc_q), 32'(e.prod));
        check("done_latency", 32'(cyc - init_cyc), 32'(e.lat));
        check("add_count", 32'(add_cnt), 32'(e.adds));
        check("shift_count", 32'(shift_cnt), 32'(W));
        if (rearm_left[e.id] > 0) begin
          rearm_left[e.id]--;
          rearm_pend[e.id] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (o_busy === 1'b0 && sbq.size() == 0) break;
    end
    check("idle_reached", 32'(o_busy === 1'b0 && sbq.size() == 0), 32'd1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    check("reset_outs", outs(), 32'd0);
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  int  base_d;
  int  base_g;
  bit  hit;

  initial begin
    i_rst = 1'b1;
    i_req = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      a_op[k]       = 8'(k + 3);
      b_op[k]       = 8'h00;
      sticky[k]     = 1'b0;
      rearm_pend[k] = 1'b0;
      rearm_left[k] = 0;
    end
    tick();
    check("por_outs", outs(), 32'd0);
    i_rst = 1'b0;
    tick();
    check("idle_outs", outs(), 32'd0);

    // Single requester, multiplier 0x03.
    a_op[0] = 8'h05;
    b_op[0] = 8'h03;
    push(0);
    i_req = 4'b0001;
    tick();
    check("single_gnt", 32'(o_gnt), 32'(4'b0001));
    check("single_load", 32'(o_load), 32'd1);
    check("single_busy", 32'(o_busy), 32'd1);
    wait_idle(60);

    // All four request at once from reset; back-to-back service in index order.
    do_reset();
    a_op[0] = 8'h12; b_op[0] = 8'h81;
    a_op[1] = 8'h7F; b_op[1] = 8'h00;
    a_op[2] = 8'hFF; b_op[2] = 8'hFF;
    a_op[3] = 8'h0A; b_op[3] = 8'h5A;
    push(0); push(1); push(2); push(3);
    base_d = done_total;
    base_g = gnt_total;
    i_req = 4'b1111;
    for (int n = 0; n < 400 && done_total < base_d + 4; n++) begin
      tick();
      if (gnt_total > base_g && done_total < base_d + 4)
        check("busy_held", 32'(o_busy), 32'd1);
      if (o_gnt !== '0 && gnt_total > base_g + 1)
        check("b2b_gap", 32'(cyc - last_done_cyc), 32'd1);
    end
    check("four_done", 32'(done_total - base_d), 32'd4);
    wait_idle(10);

    // Requesters 0 and 2 re-request right after each completion.
    do_reset();
    a_op[0] = 8'h21; b_op[0] = 8'h11;
    a_op[2] = 8'h33; b_op[2] = 8'hA0;
    rearm_left[0] = 1;
    rearm_left[2] = 1;
    push(0); push(2); push(0); push(2);
    i_req = 4'b0101;
    wait_idle(300);

    // Reset during an ADD of requester 1 abandons the operation.
    a_op[1] = 8'h09; b_op[1] = 8'h03;
    push(1);
    i_req = 4'b0010;
    hit = 1'b0;
    for (int n = 0; n < 30 && !hit; n++) begin
      tick();
      if (o_add === 1'b1 && o_sel === 2'd1) hit = 1'b1;
    end
    check("add_reached", 32'(hit), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_reset_outs", outs(), 32'd0);
    sbq.delete();
    base_d = done_total;
    repeat (3) tick();
    check("no_done_in_reset", 32'(done_total - base_d), 32'd0);
    i_rst = 1'b0;
    a_op[3] = 8'h0C; b_op[3] = 8'h07;
    push(3);
    i_req = 4'b1000;
    tick();
    check("gnt_after_reset", 32'(o_gnt), 32'(4'b1000));
    wait_idle(60);
    check("no_stray_done", 32'(done_total - base_d), 32'd1);

    // Multiplier extremes: 0x00 then 0xFF.
    a_op[2] = 8'hAB; b_op[2] = 8'h00;
    push(2);
    i_req = 4'b0100;
    wait_idle(60);
    a_op[2] = 8'hCD; b_op[2] = 8'hFF;
    push(2);
    i_req = 4'b0100;
    wait_idle(60);

    // Requesters 1 and 3 hold their requests continuously.
    do_reset();
    a_op[1] = 8'h11; b_op[1] = 8'h02;
    a_op[3] = 8'h13; b_op[3] = 8'h04;
    sticky[1] = 1'b1;
    sticky[3] = 1'b1;
`ifdef MULT_SCHED_RR_EN
    push(1); push(3); push(1);
`else
    push(1); push(1); push(1);
`endif
    base_g = gnt_total;
    i_req = 4'b1010;
    for (int n = 0; n < 200 && gnt_total < base_g + 3; n++) tick();
    check("three_grants", 32'(gnt_total - base_g), 32'd3);
    i_req = '0;
    sticky[1] = 1'b0;
    sticky[3] = 1'b0;
    wait_idle(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
